// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazards and flushes, downstream hold, and saturating stall/flush counters.
module id_ex_register #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ID_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rd,
  input  logic                      ID_UsesRs1,
  input  logic                      ID_UsesRs2,
  input  logic [DATA_WIDTH-1:0]     ID_RegData1,
  input  logic [DATA_WIDTH-1:0]     ID_RegData2,
  input  logic [DATA_WIDTH-1:0]     ID_Imm,
  input  logic [DATA_WIDTH-1:0]     ID_PC,
  input  logic [7:0]                ID_Ctrl,
  input  logic                      EX_Flush,
  input  logic                      MEM_Hold,
  output logic                      ID_EX_Valid,
  output logic [REG_ADDR_WIDTH-1:0] ID_EX_Rs1,
  output logic [REG_ADDR_WIDTH-1:0] ID_EX_Rs2,
  output logic [REG_ADDR_WIDTH-1:0] ID_EX_Rd,
  output logic [DATA_WIDTH-1:0]     ID_EX_RegData1,
  output logic [DATA_WIDTH-1:0]     ID_EX_RegData2,
  output logic [DATA_WIDTH-1:0]     ID_EX_Imm,
  output logic [DATA_WIDTH-1:0]     ID_EX_PC,
  output logic [7:0]                ID_EX_Ctrl,
  output logic                      Stall,
  output logic [CNT_WIDTH-1:0]      StallCount,
  output logic [CNT_WIDTH-1:0]      FlushCount
);

  localparam int CTRL_MEMREAD = 6;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rdata1;
    logic [DATA_WIDTH-1:0]     rdata2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic [7:0]                ctrl;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_STALL
  } action_e;

  stage_t                 stage_q, stage_d;
  stage_t                 id_stage;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
  logic                   rs1_hit, rs2_hit;
  logic                   load_use;
  action_e                action;

  // Hazard only when the instruction in EX is a real load to a non-zero rd.
  always_comb begin
    rs1_hit  = ID_UsesRs1 && (ID_Rs1 == stage_q.rd);
    rs2_hit  = ID_UsesRs2 && (ID_Rs2 == stage_q.rd);
    load_use = ID_Valid && stage_q.valid && stage_q.ctrl[CTRL_MEMREAD] &&
               (stage_q.rd != '0) && (rs1_hit || rs2_hit);
  end

  assign Stall = MEM_Hold || (load_use && !EX_Flush);

  always_comb begin
    if (MEM_Hold) begin
      action = ACT_HOLD;
    end else if (EX_Flush) begin
      action = ACT_FLUSH;
    end else if (load_use) begin
      action = ACT_STALL;
    end else begin
      action = ACT_LOAD;
    end
  end

  always_comb begin
    id_stage.valid  = ID_Valid;
    id_stage.rs1    = ID_Rs1;
    id_stage.rs2    = ID_Rs2;
    id_stage.rd     = ID_Rd;
    id_stage.rdata1 = ID_RegData1;
    id_stage.rdata2 = ID_RegData2;
    id_stage.imm    = ID_Imm;
    id_stage.pc     = ID_PC;
    // An invalid slot must never carry live control into EX.
    id_stage.ctrl   = ID_Valid ? ID_Ctrl : 8'h00;
  end

  always_comb begin
    stage_d     = stage_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (action)
      ACT_HOLD: begin
        stage_d = stage_q;
      end
      ACT_FLUSH: begin
        stage_d     = '0;
        flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + 1'b1;
      end
      ACT_STALL: begin
        stage_d     = '0;
        stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
      end
      default: begin
        stage_d = id_stage;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_EX_Valid    = stage_q.valid;
  assign ID_EX_Rs1      = stage_q.rs1;
  assign ID_EX_Rs2      = stage_q.rs2;
  assign ID_EX_Rd       = stage_q.rd;
  assign ID_EX_RegData1 = stage_q.rdata1;
  assign ID_EX_RegData2 = stage_q.rdata2;
  assign ID_EX_Imm      = stage_q.imm;
  assign ID_EX_PC       = stage_q.pc;
  assign ID_EX_Ctrl     = stage_q.ctrl;
  assign StallCount     = stall_cnt_q;
  assign FlushCount     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized and directed bench for id_ex_register against a behavioural model;
// a second instance with 2-bit counters covers counter saturation.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid;
  logic [4:0]  ID_Rs1, ID_Rs2, ID_Rd;
  logic        ID_UsesRs1, ID_UsesRs2;
  logic [31:0] ID_RegData1, ID_RegData2, ID_Imm, ID_PC;
  logic [7:0]  ID_Ctrl;
  logic        EX_Flush, MEM_Hold;

  logic        ID_EX_Valid;
  logic [4:0]  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
  logic [31:0] ID_EX_RegData1, ID_EX_RegData2, ID_EX_Imm, ID_EX_PC;
  logic [7:0]  ID_EX_Ctrl;
  logic        Stall;
  logic [15:0] StallCount, FlushCount;

  logic        s_Valid;
  logic [4:0]  s_Rs1, s_Rs2, s_Rd;
  logic [31:0] s_RegData1, s_RegData2, s_Imm, s_PC;
  logic [7:0]  s_Ctrl;
  logic        s_Stall;
  logic [1:0]  s_StallCount, s_FlushCount;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_Rd(ID_Rd), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .ID_RegData1(ID_RegData1), .ID_RegData2(ID_RegData2), .ID_Imm(ID_Imm),
    .ID_PC(ID_PC), .ID_Ctrl(ID_Ctrl), .EX_Flush(EX_Flush), .MEM_Hold(MEM_Hold),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegData1(ID_EX_RegData1),
    .ID_EX_RegData2(ID_EX_RegData2), .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC),
    .ID_EX_Ctrl(ID_EX_Ctrl), .Stall(Stall), .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  id_ex_register #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_Rd(ID_Rd), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .ID_RegData1(ID_RegData1), .ID_RegData2(ID_RegData2), .ID_Imm(ID_Imm),
    .ID_PC(ID_PC), .ID_Ctrl(ID_Ctrl), .EX_Flush(EX_Flush), .MEM_Hold(MEM_Hold),
    .ID_EX_Valid(s_Valid), .ID_EX_Rs1(s_Rs1), .ID_EX_Rs2(s_Rs2), .ID_EX_Rd(s_Rd),
    .ID_EX_RegData1(s_RegData1), .ID_EX_RegData2(s_RegData2), .ID_EX_Imm(s_Imm),
    .ID_EX_PC(s_PC), .ID_EX_Ctrl(s_Ctrl), .Stall(s_Stall),
    .StallCount(s_StallCount), .FlushCount(s_FlushCount)
  );

  // Reference state: what EX currently holds, plus unbounded event counts.
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc;
  logic [7:0]  m_ctrl;
  int          m_stalls, m_flushes;

  int n_cmp = 0;
  int n_err = 0;
  logic last_stall;

  localparam logic [7:0] C_LW   = 8'b1101_0000; // RegWrite, MemRead, MemToReg
  localparam logic [7:0] C_ADD  = 8'b1000_0010; // RegWrite, ALUOp=2
  localparam logic [7:0] C_ADDI = 8'b1000_1010; // RegWrite, ALUSrc, ALUOp=2

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? 64'(lim) : 64'(v);
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc = '0; m_ctrl = '0;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic u1, input logic u2,
                           input logic [7:0] c);
    ID_Valid = v; ID_Rs1 = r1; ID_Rs2 = r2; ID_Rd = rd;
    ID_UsesRs1 = u1; ID_UsesRs2 = u2; ID_Ctrl = c;
    ID_RegData1 = $urandom; ID_RegData2 = $urandom;
    ID_Imm = $urandom; ID_PC = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
  endtask

  task automatic rand_instr();
    set_instr(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? C_LW : 8'($urandom));
  endtask

  // One clock: check combinational Stall, advance the model, check registers.
  task automatic step();
    logic hazard, exp_stall;
    #1;
    hazard = ID_Valid && m_valid && m_ctrl[6] && (m_rd != 0) &&
             ((ID_UsesRs1 && ID_Rs1 == m_rd) || (ID_UsesRs2 && ID_Rs2 == m_rd));
    exp_stall = MEM_Hold || (hazard && !EX_Flush);
    last_stall = Stall;
    chk("stall", {63'd0, Stall}, {63'd0, exp_stall});
    chk("stall_sat", {63'd0, s_Stall}, {63'd0, exp_stall});
    @(posedge clk);
    if (rst) begin
      model_clear(); m_stalls = 0; m_flushes = 0;
    end else if (MEM_Hold) begin
      // nothing moves
    end else if (EX_Flush) begin
      model_clear(); m_flushes++;
    end else if (hazard) begin
      model_clear(); m_stalls++;
    end else begin
      m_valid = ID_Valid; m_rs1 = ID_Rs1; m_rs2 = ID_Rs2; m_rd = ID_Rd;
      m_d1 = ID_RegData1; m_d2 = ID_RegData2; m_imm = ID_Imm; m_pc = ID_PC;
      m_ctrl = ID_Valid ? ID_Ctrl : 8'h00;
    end
    #1;
    chk("valid", {63'd0, ID_EX_Valid}, {63'd0, m_valid});
    chk("regs", {49'd0, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd}, {49'd0, m_rs1, m_rs2, m_rd});
    chk("ctrl", {56'd0, ID_EX_Ctrl}, {56'd0, m_ctrl});
    chk("data", {ID_EX_RegData1, ID_EX_RegData2}, {m_d1, m_d2});
    chk("imm_pc", {ID_EX_Imm, ID_EX_PC}, {m_imm, m_pc});
    chk("stall_cnt", {48'd0, StallCount}, sat(m_stalls, 16));
    chk("flush_cnt", {48'd0, FlushCount}, sat(m_flushes, 16));
    chk("sat_state", {8'd0, s_Valid, s_Rs1, s_Rs2, s_Rd, s_Ctrl, s_PC},
                     {8'd0, m_valid, m_rs1, m_rs2, m_rd, m_ctrl, m_pc});
    chk("sat_data", {s_RegData1, s_RegData2}, {m_d1, m_d2});
    chk("sat_imm", {32'd0, s_Imm}, {32'd0, m_imm});
    chk("sat_stall_cnt", {62'd0, s_StallCount}, sat(m_stalls, 2));
    chk("sat_flush_cnt", {62'd0, s_FlushCount}, sat(m_flushes, 2));
  endtask

  initial begin
    logic [31:0] pc_snap;
    logic        prev_stall;
    rst = 1'b1; EX_Flush = 1'b0; MEM_Hold = 1'b0;
    set_instr(1'b0, 0, 0, 0, 0, 0, 8'h00);
    model_clear(); m_stalls = 0; m_flushes = 0;
    @(posedge clk); #1;

    // Reset with random inputs: everything zero, Stall follows MEM_Hold only.
    for (int i = 0; i < 2; i++) begin
      rand_instr();
      EX_Flush = 1'($urandom_range(0, 1));
      MEM_Hold = 1'($urandom_range(0, 1));
      step();
      chk("rst_valid", {63'd0, ID_EX_Valid}, 64'd0);
      chk("rst_cnt", {32'd0, StallCount, FlushCount}, 64'd0);
    end
    rst = 1'b0; EX_Flush = 1'b0; MEM_Hold = 1'b0;

    // Load-use: lw x5 then add x6, x5 -> one bubble, then the add loads.
    set_instr(1, 1, 2, 5, 1, 0, C_LW); step();
    set_instr(1, 5, 3, 6, 1, 1, C_ADD); step();
    chk("lu_stall", {63'd0, last_stall}, 64'd1);
    chk("lu_bubble", {63'd0, ID_EX_Valid}, 64'd0);
    chk("lu_count", {48'd0, StallCount}, 64'd1);
    step();
    chk("lu_release", {63'd0, last_stall}, 64'd0);
    chk("lu_loaded_rd", {59'd0, ID_EX_Rd}, 64'd6);

    // No false stalls: lw x0, and a non-reading rs2 field.
    set_instr(1, 1, 2, 0, 1, 0, C_LW); step();
    set_instr(1, 0, 0, 7, 1, 1, C_ADD); step();
    chk("x0_no_stall", {63'd0, last_stall}, 64'd0);
    set_instr(1, 1, 2, 5, 1, 0, C_LW); step();
    set_instr(1, 3, 5, 7, 1, 0, C_ADDI); step();
    chk("rs2_unused_no_stall", {63'd0, last_stall}, 64'd0);

    // Flush beats a pending load-use.
    set_instr(1, 1, 2, 5, 1, 0, C_LW); step();
    set_instr(1, 5, 3, 6, 1, 1, C_ADD); EX_Flush = 1'b1; step();
    EX_Flush = 1'b0;
    chk("flush_no_stall", {63'd0, last_stall}, 64'd0);
    chk("flush_count", {48'd0, FlushCount}, 64'd1);
    chk("flush_stall_cnt", {48'd0, StallCount}, 64'd1);

    // Hold for 3 cycles with changing inputs.
    set_instr(1, 4, 4, 9, 1, 1, C_ADD); step();
    pc_snap = ID_EX_PC;
    MEM_Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_instr(); EX_Flush = 1'($urandom_range(0, 1)); step();
      chk("hold_stall", {63'd0, last_stall}, 64'd1);
      chk("hold_pc", {32'd0, ID_EX_PC}, {32'd0, pc_snap});
    end
    MEM_Hold = 1'b0; EX_Flush = 1'b0;
    set_instr(1, 1, 1, 3, 1, 1, C_ADD); step();
    chk("hold_release_valid", {63'd0, ID_EX_Valid}, 64'd1);

    // Saturation of the 2-bit counter after 5 hazards.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_instr(1, 1, 2, 5, 1, 0, C_LW); step();
      set_instr(1, 0, 5, 6, 0, 1, C_ADD); step(); step();
    end
    chk("sat_stall_3", {62'd0, s_StallCount}, 64'd3);
    chk("wide_stall_5", {48'd0, StallCount}, 64'd5);

    // Random traffic; a stalled instruction is presented again, as IF/ID would.
    prev_stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      MEM_Hold = ($urandom_range(0, 99) < 15);
      EX_Flush = ($urandom_range(0, 99) < 10);
      if (!prev_stall) rand_instr();
      step();
      prev_stall = last_stall;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
